gameport_multi: RTL and testbench
=================================

Name: gameport_multi

Overview:
- Parametrised PC gameport (port 201h) emulator: replaces the fixed 4-axis, 8-bit one-shot timer in the MiST top with N axes of configurable counter width.
- Adds:
  - per-axis snapshot of position at trigger;
  - presence mask;
  - busy flag;
  - prescaler generalised by a shift parameter.
- Sits between the user_io joystick outputs and the system GPIO_IN/GPIO_WR pins, clocked by clk_cpu.

Parameters:
- NUM_AXES, 4, number of analog one-shot channels; must be even.
- NUM_BUTTONS, 4, number of fire buttons; must be even.
- CNT_W, 8, width of axis position and tick counter.
- PRE_SHIFT, 4, prescaler period P = (cpu_speed+1) << PRE_SHIFT clk_cpu cycles per tick.
- DEADZONE, 4, magnitude threshold used only with the optional feature.

Ports:
- clk_cpu  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- cpu_speed  in  5  CPU divider setting; scales tick period.
- trig  in  1  single-cycle write strobe to port 201h (GPIO_WR).
- swap  in  1  exchanges lower/upper halves of axes and buttons.
- axis_present  in  NUM_AXES  1 = stick connected on that axis.
- axis_pos  in  NUM_AXES*CNT_W  signed two's-complement positions; axis i at [i*CNT_W +: CNT_W].
- buttons  in  NUM_BUTTONS  active-high pressed.
- axis_out  out  NUM_AXES  one-shot outputs; 1 = timing.
- btn_out_n  out  NUM_BUTTONS  active-low button bits.
- busy  out  1  measurement in progress.

Behaviour:
- Reset state (asynchronous):
  - cnt = all-ones (idle), pre = 0;
  - axis_out = 0, btn_out_n = all-ones, busy = 0;
  - targets = 0.
- Swap mapping when swap = 1:
  - axis i maps to (i + NUM_AXES/2) mod NUM_AXES;
  - button j maps to (j + NUM_BUTTONS/2) mod NUM_BUTTONS.
- Buttons: btn_out_n <= ~buttons (after swap mapping) every cycle, 1-cycle latency.
- Trigger, sampled at edge E0:
  - cnt <= 0, pre <= 0, busy <= 1, axis_out <= all-ones;
  - target[i] <= {~pos[MSB], pos[MSB-1:0]} (offset binary) of the swapped axis, latched. Later changes of axis_pos do not affect the running measurement.
- Tick generation:
  - while cnt != all-ones, pre increments each cycle;
  - when pre >= P-1: pre <= 0 and cnt <= cnt+1;
  - the >= compare makes a mid-count cpu_speed decrease safe;
  - cnt reaches k at edge E0 + k*P.
- Axis clear:
  - while busy, present axis i clears one cycle after cnt == target[i] is observed;
  - high time = target*P + 1 cycles;
  - target 0 gives a 1-cycle pulse.
- Absent axis: stays 1 until timeout.
- Timeout:
  - when cnt == all-ones and busy, next edge forces axis_out = 0 and busy = 0;
  - target all-ones coincides with timeout, no conflict.
- States:
  - IDLE: cnt all-ones, busy 0.
  - COUNT: busy 1.
  - COUNT -> IDLE on timeout.
  - IDLE/COUNT -> COUNT on trig.
- Simultaneous events:
  - trig in COUNT restarts from E0 (retrigger), all bits re-set to 1;
  - trig coincident with timeout: trig wins.
- Reset mid-count returns to the reset state immediately.

Optional Feature:
- Macro GAMEPORT_DEADZONE_EN.
- When defined: any latched position with |pos| < DEADZONE snaps to 0 (target = 2^(CNT_W-1)) at trigger; -2^(CNT_W-1) uses magnitude 2^(CNT_W-1).
- When undefined: positions are used unmodified; DEADZONE is ignored.

Test Plan:
- Defaults, cpu_speed=0 (P=16), pos axis0=0, all present, trig -> axis_out[0] high exactly 2049 cycles; busy drops at E0+4081.
- pos=-128 on axis1, trig -> axis_out[1] high 1 cycle; pos=127 -> high 4081 cycles, clears together with timeout.
- axis_present=4'b1011, trig -> axis_out[2] stays 1 until E0+4081, then 0 with busy.
- cpu_speed=3 (P=64), pos=0, retrigger at E0+1000 -> axis_out[0] stays 1 and clears 8193 cycles after the second trig.
- swap=1, axis_pos axis0=-128, axis2=0, buttons=4'b0001 -> axis_out[2] 1-cycle pulse, axis_out[0] 2049 cycles; btn_out_n=4'b1011.
- With GAMEPORT_DEADZONE_EN, pos=3 -> pulse 2049 cycles; pos=4 -> 2113 cycles; without the macro, pos=3 -> 2097 cycles.

Source files
------------

// File: rtl/gameport_multi.sv
// Parametrised PC gameport (201h) one-shot timer with N axes, swap, presence mask and busy flag.
// Optional deadzone snapping of latched positions is enabled by defining GAMEPORT_DEADZONE_EN.
module gameport_multi #(
  parameter int unsigned NUM_AXES    = 4,
  parameter int unsigned NUM_BUTTONS = 4,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned PRE_SHIFT   = 4,
  parameter int unsigned DEADZONE    = 4
) (
  input  logic                        clk_cpu,
  input  logic                        reset,
  input  logic [4:0]                  cpu_speed,
  input  logic                        trig,
  input  logic                        swap,
  input  logic [NUM_AXES-1:0]         axis_present,
  input  logic [NUM_AXES*CNT_W-1:0]   axis_pos,
  input  logic [NUM_BUTTONS-1:0]      buttons,
  output logic [NUM_AXES-1:0]         axis_out,
  output logic [NUM_BUTTONS-1:0]      btn_out_n,
  output logic                        busy
);

  localparam int unsigned PRE_W = 6 + PRE_SHIFT;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_MID = {1'b1, {(CNT_W-1){1'b0}}};

  typedef enum logic {ST_IDLE = 1'b0, ST_COUNT = 1'b1} state_e;

  state_e                          state_q, state_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic [PRE_W-1:0]                pre_q, pre_d;
  logic [NUM_AXES-1:0]             axis_q, axis_d;
  logic [NUM_BUTTONS-1:0]          btn_q, btn_d;
  logic [NUM_AXES-1:0][CNT_W-1:0]  tgt_q, tgt_d;

  logic [NUM_AXES-1:0][CNT_W-1:0]  sw_pos;
  logic [NUM_AXES-1:0][CNT_W-1:0]  tgt_c;
  logic [NUM_AXES-1:0]             sw_present;
  logic [NUM_BUTTONS-1:0]          sw_btn;
  logic [PRE_W-1:0]                period_m1_c;

  assign period_m1_c = ((PRE_W'(cpu_speed) + PRE_W'(1)) << PRE_SHIFT) - PRE_W'(1);

  // Swap routing and trigger-time target conversion (signed -> offset binary)
  for (genvar g = 0; g < NUM_AXES; g++) begin : g_axis
    localparam int unsigned SRC = (g + NUM_AXES / 2) % NUM_AXES;
    logic dz_hit;

    assign sw_pos[g]     = swap ? axis_pos[SRC*CNT_W +: CNT_W] : axis_pos[g*CNT_W +: CNT_W];
    assign sw_present[g] = swap ? axis_present[SRC] : axis_present[g];

`ifdef GAMEPORT_DEADZONE_EN
    logic [CNT_W-1:0] mag;
    // Unsigned magnitude; the most negative value yields 2^(CNT_W-1)
    assign mag    = sw_pos[g][CNT_W-1] ? (~sw_pos[g] + CNT_W'(1)) : sw_pos[g];
    assign dz_hit = (mag < CNT_W'(DEADZONE));
`else
    assign dz_hit = 1'b0 & (DEADZONE != 32'd0);
`endif

    assign tgt_c[g] = dz_hit ? CNT_MID : {~sw_pos[g][CNT_W-1], sw_pos[g][CNT_W-2:0]};
  end

  for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_btn
    localparam int unsigned SRC = (g + NUM_BUTTONS / 2) % NUM_BUTTONS;
    assign sw_btn[g] = swap ? buttons[SRC] : buttons[g];
  end

  // State and datapath registers
  always_ff @(posedge clk_cpu or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= CNT_MAX;
      pre_q   <= '0;
      axis_q  <= '0;
      btn_q   <= '1;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pre_q   <= pre_d;
      axis_q  <= axis_d;
      btn_q   <= btn_d;
      tgt_q   <= tgt_d;
    end
  end

  // Next state: trigger (re)starts, counter saturation times out
  always_comb begin
    state_d = state_q;
    if (trig) begin
      state_d = ST_COUNT;
    end else if (state_q == ST_COUNT && cnt_q == CNT_MAX) begin
      state_d = ST_IDLE;
    end
  end

  // Datapath next values; trigger has priority over tick, clear and timeout
  always_comb begin
    cnt_d  = cnt_q;
    pre_d  = pre_q;
    axis_d = axis_q;
    tgt_d  = tgt_q;
    btn_d  = ~sw_btn;
    if (trig) begin
      cnt_d  = '0;
      pre_d  = '0;
      axis_d = '1;
      tgt_d  = tgt_c;
    end else begin
      if (cnt_q != CNT_MAX) begin
        if (pre_q >= period_m1_c) begin
          pre_d = '0;
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          pre_d = pre_q + PRE_W'(1);
        end
      end
      if (state_q == ST_COUNT) begin
        if (cnt_q == CNT_MAX) begin
          axis_d = '0;
        end else begin
          for (int i = 0; i < NUM_AXES; i++) begin
            if (sw_present[i] && cnt_q == tgt_q[i]) axis_d[i] = 1'b0;
          end
        end
      end
    end
  end

  assign axis_out  = axis_q;
  assign btn_out_n = btn_q;
  assign busy      = (state_q == ST_COUNT);

endmodule

// File: tb/tb_gameport_multi.sv
// Directed-vector bench for gameport_multi: pulse widths, timeout, swap, retrigger and reset.
module tb_gameport_multi;

  logic        clk_cpu = 1'b0;
  logic        reset;
  logic [4:0]  cpu_speed;
  logic        trig;
  logic        swap;
  logic [3:0]  axis_present;
  logic [31:0] axis_pos;
  logic [3:0]  buttons;
  logic [3:0]  axis_out;
  logic [3:0]  btn_out_n;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;
  int clr_at [4];
  int busy_at;
  int exp_clr [4];

  gameport_multi dut (
    .clk_cpu      (clk_cpu),
    .reset        (reset),
    .cpu_speed    (cpu_speed),
    .trig         (trig),
    .swap         (swap),
    .axis_present (axis_present),
    .axis_pos     (axis_pos),
    .buttons      (buttons),
    .axis_out     (axis_out),
    .btn_out_n    (btn_out_n),
    .busy         (busy)
  );

  always #5 clk_cpu = ~clk_cpu;

  // Caller sits at a negedge; returns at the negedge right after the trigger edge
  task automatic pulse_trig();
    trig = 1'b1;
    @(negedge clk_cpu);
    trig = 1'b0;
  endtask

  // Records, in cycles after the trigger edge, when each axis and busy first read 0
  task automatic measure(input int limit);
    bit done;
    for (int k = 0; k < 4; k++) clr_at[k] = -1;
    busy_at = -1;
    for (int m = 0; m <= limit; m++) begin
      for (int k = 0; k < 4; k++) if (clr_at[k] < 0 && axis_out[k] === 1'b0) clr_at[k] = m;
      if (busy_at < 0 && busy === 1'b0) busy_at = m;
      done = (busy_at >= 0);
      for (int k = 0; k < 4; k++) if (clr_at[k] < 0) done = 1'b0;
      if (done) break;
      @(negedge clk_cpu);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; trig = 1'b0; swap = 1'b0; cpu_speed = 5'd0;
    axis_present = 4'hF; axis_pos = '0; buttons = 4'b0110;
    repeat (3) @(negedge clk_cpu);
    vectors++;
    if (axis_out !== 4'h0) begin miscompares++; $display("FAIL reset axis_out got %b exp 0000", axis_out); end
    vectors++;
    if (btn_out_n !== 4'hF) begin miscompares++; $display("FAIL reset btn_out_n got %b exp 1111", btn_out_n); end
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL reset busy got %b exp 0", busy); end
    reset = 1'b0;
    buttons = 4'b0000;
    repeat (2) @(negedge clk_cpu);
  endtask

  task automatic test_buttons();
    buttons = 4'b0101;
    #1;
    vectors++;
    if (btn_out_n !== 4'b1111) begin miscompares++; $display("FAIL btn latency got %b exp 1111", btn_out_n); end
    @(negedge clk_cpu);
    vectors++;
    if (btn_out_n !== 4'b1010) begin miscompares++; $display("FAIL btn value got %b exp 1010", btn_out_n); end
    buttons = 4'b0000;
    @(negedge clk_cpu);
  endtask

  task automatic check_meas(input string name, input int exp_busy);
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (clr_at[k] !== exp_clr[k]) begin
        miscompares++;
        $display("FAIL %s axis%0d high got %0d exp %0d", name, k, clr_at[k], exp_clr[k]);
      end
    end
    vectors++;
    if (busy_at !== exp_busy) begin
      miscompares++;
      $display("FAIL %s busy drop got %0d exp %0d", name, busy_at, exp_busy);
    end
  endtask

  task automatic test_center();
    cpu_speed = 5'd0; axis_present = 4'hF; axis_pos = 32'h0000_0000;
    pulse_trig();
    measure(20000);
    exp_clr = '{2049, 2049, 2049, 2049};
    check_meas("center", 4081);
  endtask

  task automatic test_extremes();
    // axis3=-64, axis2=64, axis1=-128, axis0=127
    axis_pos = {8'hC0, 8'h40, 8'h80, 8'h7F};
    pulse_trig();
    measure(20000);
    exp_clr = '{4081, 1, 3073, 1025};
    check_meas("extremes", 4081);
  endtask

  task automatic test_absent();
    axis_present = 4'b1011; axis_pos = '0;
    pulse_trig();
    measure(20000);
    exp_clr = '{2049, 2049, 4081, 2049};
    check_meas("absent", 4081);
    axis_present = 4'hF;
  endtask

  task automatic test_latch();
    axis_pos = '0;
    pulse_trig();
    axis_pos = {8'h7F, 8'h80, 8'h7F, 8'h80};
    measure(20000);
    exp_clr = '{2049, 2049, 2049, 2049};
    check_meas("latch", 4081);
  endtask

  task automatic test_retrigger();
    cpu_speed = 5'd3; axis_pos = '0;
    pulse_trig();
    repeat (999) @(negedge clk_cpu);
    vectors++;
    if (axis_out !== 4'hF || busy !== 1'b1) begin
      miscompares++; $display("FAIL retrig pre axis_out=%b busy=%b exp 1111/1", axis_out, busy);
    end
    pulse_trig();
    measure(40000);
    exp_clr = '{8193, 8193, 8193, 8193};
    check_meas("retrig", 16321);
    cpu_speed = 5'd0;
  endtask

  task automatic test_trig_at_timeout();
    axis_pos = '0;
    pulse_trig();
    repeat (4080) @(negedge clk_cpu);
    pulse_trig();
    vectors++;
    if (axis_out !== 4'hF || busy !== 1'b1) begin
      miscompares++; $display("FAIL trig_timeout axis_out=%b busy=%b exp 1111/1", axis_out, busy);
    end
    measure(20000);
    exp_clr = '{2049, 2049, 2049, 2049};
    check_meas("trig_timeout", 4081);
  endtask

  task automatic test_swap();
    swap = 1'b1; buttons = 4'b0001;
    axis_pos = {8'hC0, 8'h00, 8'h40, 8'h80};
    @(negedge clk_cpu);
    vectors++;
    if (btn_out_n !== 4'b1011) begin miscompares++; $display("FAIL swap btn got %b exp 1011", btn_out_n); end
    pulse_trig();
    measure(20000);
    exp_clr = '{2049, 1025, 1, 3073};
    check_meas("swap", 4081);
    swap = 1'b0; buttons = 4'b0000;
    @(negedge clk_cpu);
  endtask

  task automatic test_deadzone();
    // axis3=-4, axis2=-3, axis1=4, axis0=3
    axis_pos = {8'hFC, 8'hFD, 8'h04, 8'h03};
    pulse_trig();
    measure(20000);
`ifdef GAMEPORT_DEADZONE_EN
    exp_clr = '{2049, 2113, 2049, 1985};
`else
    exp_clr = '{2097, 2113, 2001, 1985};
`endif
    check_meas("deadzone", 4081);
  endtask

  task automatic test_mid_reset();
    axis_pos = '0; buttons = 4'b0001;
    pulse_trig();
    repeat (100) @(negedge clk_cpu);
    reset = 1'b1;
    #1;
    vectors++;
    if (axis_out !== 4'h0 || busy !== 1'b0 || btn_out_n !== 4'hF) begin
      miscompares++;
      $display("FAIL mid_reset axis_out=%b busy=%b btn=%b exp 0000/0/1111", axis_out, busy, btn_out_n);
    end
    @(negedge clk_cpu);
    reset = 1'b0;
    repeat (3) @(negedge clk_cpu);
    vectors++;
    if (busy !== 1'b0 || axis_out !== 4'h0 || btn_out_n !== 4'b1110) begin
      miscompares++;
      $display("FAIL post_reset axis_out=%b busy=%b btn=%b exp 0000/0/1110", axis_out, busy, btn_out_n);
    end
    buttons = 4'b0000;
  endtask

  initial begin
    test_reset();
    test_buttons();
    test_center();
    test_extremes();
    test_absent();
    test_latch();
    test_retrigger();
    test_trig_at_timeout();
    test_swap();
    test_deadzone();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
